mult_op_dispatcher: RTL

MULT_OP_DISPATCHER -- requirements
Module: mult_op_dispatcher

---
 rtl/mult_pkg.sv | 14 +
 rtl/mult_op_fifo.sv | 64 ++++++
 rtl/mult_op_dispatcher.sv | 137 +++++++++++++
 3 files changed

// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared types and default sizes for the multiplier operand dispatcher
package mult_pkg;

   localparam int DEFAULT_NUM_BITS = 32;
   localparam int DEFAULT_LATENCY  = 68;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_HOLD
   } disp_state_t;

endpackage

// File: rtl/mult_op_fifo.sv
// rtl/mult_op_fifo.sv - operand-pair FIFO with sign flag, power-of-two depth
module mult_op_fifo #(
   parameter int NUM_BITS = 32,
   parameter int DEPTH    = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      push,
   input  logic [2*NUM_BITS-1:0]     push_data,
   input  logic                      push_sign,
   input  logic                      pop,
   output logic [2*NUM_BITS-1:0]     pop_data,
   output logic                      pop_sign,
   output logic                      full,
   output logic                      empty,
   output logic [$clog2(DEPTH):0]    count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [2*NUM_BITS:0] mem [DEPTH];
   logic [2*NUM_BITS:0] head;
   logic [PW-1:0]       wr_ptr;
   logic [PW-1:0]       rd_ptr;
   logic                push_ok;
   logic                pop_ok;

   assign full     = (count == CW'(DEPTH));
   assign empty    = (count == '0);
   assign push_ok  = push && !full;
   assign pop_ok   = pop && !empty;
   assign head     = mem[rd_ptr];
   assign pop_data = head[2*NUM_BITS-1:0];
   assign pop_sign = head[2*NUM_BITS];

   // Storage needs no reset; the pointers alone define which entries are live.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr] <= {push_sign, push_data};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (pop_ok) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         unique case ({push_ok, pop_ok})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/mult_op_dispatcher.sv
// rtl/mult_op_dispatcher.sv - queues operand pairs and issues them one at a time to a fixed-latency multiplier
module mult_op_dispatcher
   import mult_pkg::*;
#(
   parameter int NUM_BITS = DEFAULT_NUM_BITS,
   parameter int DEPTH    = 4,
   parameter int LATENCY  = DEFAULT_LATENCY
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic                in_sign,
   input  logic [NUM_BITS-1:0] in_a,
   input  logic [NUM_BITS-1:0] in_b,
   output logic                mult_load,
   output logic                mult_sign_multiplicand,
   output logic                mult_sign_multiplier,
   output logic [NUM_BITS-1:0] mult_a,
   output logic [NUM_BITS-1:0] mult_b,
   input  logic [NUM_BITS-1:0] mult_result,
   input  logic [NUM_BITS-1:0] mult_signed_result,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [NUM_BITS-1:0] out_result,
   output logic                out_sign,
   output logic                busy
);

   localparam int CNT_W = $clog2(LATENCY) + 1;

   disp_state_t           state;
   disp_state_t           state_next;
   logic [CNT_W-1:0]      lat_cnt;
   logic                  fifo_pop;
   logic                  fifo_full;
   logic                  fifo_empty;
   logic [2*NUM_BITS-1:0] fifo_data;
   logic                  fifo_sign;
   logic [$clog2(DEPTH):0] fifo_count;
   logic                  capture;
   logic [NUM_BITS-1:0]   op_a;
   logic [NUM_BITS-1:0]   op_b;
   logic                  op_sign;

   mult_op_fifo #(
      .NUM_BITS (NUM_BITS),
      .DEPTH    (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (in_valid),
      .push_data ({in_a, in_b}),
      .push_sign (in_sign),
      .pop       (fifo_pop),
      .pop_data  (fifo_data),
      .pop_sign  (fifo_sign),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   assign in_ready               = !fifo_full;
   assign mult_load              = (state == ST_ISSUE);
   assign out_valid              = (state == ST_HOLD);
   assign busy                   = (state != ST_IDLE) || (fifo_count != '0);
   assign mult_a                 = op_a;
   assign mult_b                 = op_b;
   assign mult_sign_multiplicand = op_sign;
   assign mult_sign_multiplier   = op_sign;

   always_comb begin
      state_next = state;
      fifo_pop   = 1'b0;
      capture    = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (!fifo_empty) begin
               fifo_pop   = 1'b1;
               state_next = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            state_next = ST_WAIT;
         end
         ST_WAIT: begin
            if (lat_cnt == CNT_W'(LATENCY - 1)) begin
               capture    = 1'b1;
               state_next = ST_HOLD;
            end
         end
         ST_HOLD: begin
            // Accepting the result frees the multiplier, so the next pair can issue on the same edge.
            if (out_ready) begin
               if (!fifo_empty) begin
                  fifo_pop   = 1'b1;
                  state_next = ST_ISSUE;
               end else begin
                  state_next = ST_IDLE;
               end
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         lat_cnt    <= '0;
         op_a       <= '0;
         op_b       <= '0;
         op_sign    <= 1'b0;
         out_result <= '0;
         out_sign   <= 1'b0;
      end else begin
         state <= state_next;
         if (state == ST_ISSUE) begin
            lat_cnt <= '0;
         end else if (state == ST_WAIT) begin
            lat_cnt <= lat_cnt + CNT_W'(1);
         end
         if (fifo_pop) begin
            op_a    <= fifo_data[2*NUM_BITS-1:NUM_BITS];
            op_b    <= fifo_data[NUM_BITS-1:0];
            op_sign <= fifo_sign;
         end
         if (capture) begin
            out_result <= op_sign ? mult_signed_result : mult_result;
            out_sign   <= op_sign;
         end
      end
   end

endmodule
